// File: rtl/pipelined_mux_tree_pkg.sv
// Shared constants and helpers for the pipelined mux tree.
package pkg_mux;

    localparam int DEF_DIN_W  = 4;
    localparam int DEF_NUM_CH = 4;

    // Ceiling log2. This gives the tree depth for a power-of-two channel count.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pipelined_mux_tree_cell.sv
// One registered 2:1 mux cell. The register holds its value while en is low.
module mux2_reg_cell
    import pkg_mux::*;
#(
    parameter int DIN_W = DEF_DIN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIN_W-1:0] in_lo,
    input  logic [DIN_W-1:0] in_hi,
    input  logic             s,
    output logic [DIN_W-1:0] q
);

    logic [DIN_W-1:0] q_d;
    logic [DIN_W-1:0] q_q;

    // Next value: select between the two inputs when advancing, otherwise hold.
    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = s ? in_hi : in_lo;
        end
    end

    // Cell register. Reset clears it to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/pipelined_mux_tree.sv
// NUM_CH:1 multiplexer built as a binary tree of registered 2:1 stages.
// There is one register level per tree level.
// A valid bit and the full select value travel alongside the data.
module pipelined_mux_tree
    import pkg_mux::*;
#(
    parameter int  DIN_W  = DEF_DIN_W,
    parameter int  NUM_CH = DEF_NUM_CH,
    localparam int SEL_W  = clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_CH*DIN_W-1:0] din,
    output logic                    out_valid,
    output logic [DIN_W-1:0]        dout,
    output logic [SEL_W-1:0]        out_sel
);

    // All tree nodes are flattened level by level.
    // Level k starts at node index NUM_CH - (NUM_CH >> k).
    // The last node is the root.
    localparam int NODES = NUM_CH - 1;

    logic [NODES*DIN_W-1:0] node;

    logic [SEL_W-1:0] valid_d;
    logic [SEL_W-1:0] valid_q;
    logic [SEL_W-1:0] sel_d [SEL_W];
    logic [SEL_W-1:0] sel_q [SEL_W];

    for (genvar k = 0; k < SEL_W; k++) begin : g_level
        for (genvar j = 0; j < (NUM_CH >> (k + 1)); j++) begin : g_cell
            localparam int OUT_IDX = NUM_CH - (NUM_CH >> k) + j;

            logic [DIN_W-1:0] in_lo;
            logic [DIN_W-1:0] in_hi;
            logic             s;

            if (k == 0) begin : g_leaf
                assign in_lo = din[(2*j)*DIN_W +: DIN_W];
                assign in_hi = din[(2*j+1)*DIN_W +: DIN_W];
                assign s     = sel[0];
            end else begin : g_inner
                localparam int IN_BASE = NUM_CH - (NUM_CH >> (k - 1));
                assign in_lo = node[(IN_BASE+2*j)*DIN_W +: DIN_W];
                assign in_hi = node[(IN_BASE+2*j+1)*DIN_W +: DIN_W];
                assign s     = sel_q[k-1][k];
            end

            mux2_reg_cell #(
                .DIN_W (DIN_W)
            ) u_cell (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (en),
                .in_lo (in_lo),
                .in_hi (in_hi),
                .s     (s),
                .q     (node[OUT_IDX*DIN_W +: DIN_W])
            );
        end
    end

    // Side pipeline for valid and select.
    // It shifts on en, and flush clears every valid bit regardless of en.
    always_comb begin
        for (int k = 0; k < SEL_W; k++) begin
            valid_d[k] = valid_q[k];
            sel_d[k]   = sel_q[k];
        end
        if (en) begin
            valid_d[0] = in_valid;
            sel_d[0]   = sel;
            for (int k = 1; k < SEL_W; k++) begin
                valid_d[k] = valid_q[k-1];
                sel_d[k]   = sel_q[k-1];
            end
        end
        if (flush) begin
            valid_d = '0;
        end
    end

    // Valid and select registers. Reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int k = 0; k < SEL_W; k++) begin
                sel_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            sel_q   <= sel_d;
        end
    end

    assign out_valid = valid_q[SEL_W-1];
    assign dout      = node[(NODES-1)*DIN_W +: DIN_W];
    assign out_sel   = sel_q[SEL_W-1];

endmodule

// File: tb/tb_pipelined_mux_tree.sv
// Self-checking bench for pipelined_mux_tree.
// A 4-channel instance runs the directed table and corner sequences.
// An 8-channel instance runs a random regression against a reference model.
module tb_pipelined_mux_tree;

    logic clk;
    logic rst_n;

    logic        en4, flush4, iv4;
    logic [1:0]  sel4;
    logic [15:0] din4;
    logic        ov4;
    logic [3:0]  dout4;
    logic [1:0]  osel4;

    logic        en8, flush8, iv8;
    logic [2:0]  sel8;
    logic [63:0] din8;
    logic        ov8;
    logic [7:0]  dout8;
    logic [2:0]  osel8;

    int n_checks;
    int n_fail;

    typedef struct {
        logic       en;
        logic       flush;
        logic       in_valid;
        logic [1:0] sel;
        logic       exp_valid;
        logic [3:0] exp_dout;
        logic [1:0] exp_sel;
    } vec_t;

    vec_t vecs[6];

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [2:0] s;
    } slot_t;

    slot_t pipe[3];

    pipelined_mux_tree #(.DIN_W(4), .NUM_CH(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en4),
        .flush     (flush4),
        .in_valid  (iv4),
        .sel       (sel4),
        .din       (din4),
        .out_valid (ov4),
        .dout      (dout4),
        .out_sel   (osel4)
    );

    pipelined_mux_tree #(.DIN_W(8), .NUM_CH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en8),
        .flush     (flush8),
        .in_valid  (iv8),
        .sel       (sel8),
        .din       (din8),
        .out_valid (ov8),
        .dout      (dout8),
        .out_sel   (osel8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic f, input logic v, input logic [1:0] s);
        en4    = e;
        flush4 = f;
        iv4    = v;
        sel4   = s;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check4(input string name, input logic ev, input logic [3:0] ed, input logic [1:0] es);
        checkOutput({name, "_valid"}, 64'(ov4), 64'(ev));
        if (ev) begin
            checkOutput({name, "_dout"}, 64'(dout4), 64'(ed));
            checkOutput({name, "_sel"}, 64'(osel4), 64'(es));
        end
    endtask

    int si;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0);
        din4   = 16'h4321;
        en8    = 1'b0;
        flush8 = 1'b0;
        iv8    = 1'b0;
        sel8   = 3'd0;
        din8   = 64'd0;

        // Rows of {en, flush, in_valid, sel} with the outputs expected after that edge.
        vecs[0] = '{1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 4'd0, 2'd0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 4'd1, 2'd0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 4'd2, 2'd1};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 4'd3, 2'd2};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 4'd4, 2'd3};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'd0, 2'd0};

        // Hold reset, then release. Keep en low so dout stays 0.
        repeat (2) step();
        checkOutput("rst_valid", 64'(ov4), 64'd0);
        checkOutput("rst_dout", 64'(dout4), 64'd0);
        checkOutput("rst_sel", 64'(osel4), 64'd0);
        checkOutput("rst_valid8", 64'(ov8), 64'd0);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checkOutput("idle_valid", 64'(ov4), 64'd0);
            checkOutput("idle_dout", 64'(dout4), 64'd0);
            checkOutput("idle_sel", 64'(osel4), 64'd0);
        end

        // Stream of channels 0..3.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].en, vecs[i].flush, vecs[i].in_valid, vecs[i].sel);
            step();
            check4($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_dout, vecs[i].exp_sel);
        end

        // Stall with a sample in flight.
        // The output shows the sel=0 sample loaded during the last table row.
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd2);
        step();
        checkOutput("stall_pre_valid", 64'(ov4), 64'd0);
        checkOutput("stall_pre_dout", 64'(dout4), 64'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 2'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("stall_valid", 64'(ov4), 64'd0);
            checkOutput("stall_dout", 64'(dout4), 64'd1);
            checkOutput("stall_sel", 64'(osel4), 64'd0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
        step();
        check4("stall_out", 1'b1, 4'd3, 2'd2);
        step();
        check4("stall_after", 1'b0, 4'd0, 2'd0);

        // Flush: sel=3 reaches the output as sel=1 enters.
        // The flush then drops everything still marked valid.
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd3);
        step();
        check4("flush_fill0", 1'b0, 4'd0, 2'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd1);
        step();
        check4("flush_fill1", 1'b1, 4'd4, 2'd3);
        applyStimulus(1'b1, 1'b1, 1'b1, 2'd0);
        step();
        check4("flush_edge", 1'b0, 4'd0, 2'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            check4("flush_drain", 1'b0, 4'd0, 2'd0);
        end

        // Asynchronous reset in the middle of a stream.
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd1);
        step();
        check4("mid_rst_fill", 1'b0, 4'd0, 2'd0);
        step();
        check4("mid_rst_pre", 1'b1, 4'd2, 2'd1);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 64'(ov4), 64'd0);
        checkOutput("mid_rst_dout", 64'(dout4), 64'd0);
        checkOutput("mid_rst_sel", 64'(osel4), 64'd0);
        repeat (2) step();
        #3 rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd1);
        for (int i = 0; i < 2; i++) begin
            step();
            checkOutput("post_rst_valid", 64'(ov4), 64'd0);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd2);
        step();
        checkOutput("post_rst_new0", 64'(ov4), 64'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
        step();
        check4("post_rst_new1", 1'b1, 4'd3, 2'd2);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0);

        // Random regression on the 8-channel instance.
        // The model is a 3-deep list of samples.
        // Each sample carries the word picked directly from din.
        for (int i = 0; i < 3; i++) begin
            pipe[i].v = 1'b0;
            pipe[i].d = 8'd0;
            pipe[i].s = 3'd0;
        end
        for (int n = 0; n < 400; n++) begin
            en8    = ($urandom_range(0, 9) < 8);
            flush8 = ($urandom_range(0, 19) == 0);
            iv8    = 1'($urandom_range(0, 1));
            sel8   = 3'($urandom_range(0, 7));
            din8   = {$urandom, $urandom};
            si     = int'(sel8);
            if (en8) begin
                pipe[2]   = pipe[1];
                pipe[1]   = pipe[0];
                pipe[0].v = iv8;
                pipe[0].d = din8[si*8 +: 8];
                pipe[0].s = sel8;
            end
            if (flush8) begin
                for (int i = 0; i < 3; i++) pipe[i].v = 1'b0;
            end
            step();
            checkOutput($sformatf("rand%0d_valid", n), 64'(ov8), 64'(pipe[2].v));
            if (pipe[2].v) begin
                checkOutput($sformatf("rand%0d_dout", n), 64'(dout8), 64'(pipe[2].d));
                checkOutput($sformatf("rand%0d_sel", n), 64'(osel8), 64'(pipe[2].s));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
